uart_mon_rx_mc: RTL and testbench
=================================

# uart_mon_rx_mc

Parametrised multi-channel UART receive monitor for SoC-level benches and debug fabric. Decodes serial frames on NCH independent RX lines (console, debug, co-processor UARTs), buffers each channel in its own FIFO, and merges them into one valid/ready byte stream tagged with channel and error flags. It is the next generation of the single-channel fixed-115200 tty receiver, adding channel count, frame format, buffering and backpressure.

## Interface
Parameters:
- NCH, 2: number of RX channels, 1..8.
- CLK_HZ, 25000000: clk_i frequency in Hz.
- BAUD, 115200: bit rate, shared by all channels.
- DATA_BITS, 8: data bits per frame, 5..8.
- PARITY, 0: 0 none, 1 odd, 2 even; only honoured with UART_MON_PARITY_EN.
- FIFO_DEPTH, 16: entries per channel, power of two, at least 2.

Ports:
- clk_i  in  1  single clock.
- rst_n_i  in  1  asynchronous active-low reset.
- rx_i  in  NCH  serial lines, asynchronous, idle high.
- out_valid_o  out  1  merged byte available.
- out_ready_i  in  1  consumer accepts the byte.
- out_data_o  out  DATA_BITS  received byte, LSB = first bit on the wire.
- out_ch_o  out  max(1,$clog2(NCH))  source channel.
- out_ferr_o  out  1  stop bit sampled low.
- out_perr_o  out  1  parity mismatch; tied 0 without the macro.
- ovf_o  out  NCH  sticky per-channel FIFO overflow.
- ovf_clr_i  in  1  clears all of ovf_o.

## Operation
- DIV = (CLK_HZ + BAUD/2) / BAUD, computed at elaboration. The 25 MHz / 115200 configuration gives DIV = 217 and HALF = DIV/2 = 108.
- Each rx_i bit passes through a 2-FF synchroniser. Synchroniser flops reset to 1.
- Per-channel FSM: IDLE, START, DATA, PAR, STOP, BRK.
  - IDLE to START: on synchronised low.
  - START: after HALF cycles, sample. High means false start, return to IDLE. Low goes to DATA.
  - DATA: sample every DIV cycles. DATA_BITS samples, shifted in LSB first.
  - PAR: present only with the macro and PARITY != 0. One sample, compared with the computed parity.
  - STOP: one sample. Push {data, ferr, perr} into the channel FIFO in the sample cycle. High goes to IDLE. Low (frame error or break) goes to BRK.
  - BRK: wait for synchronised high, then go to IDLE.
- FIFO full at push: drop the new entry and set ovf_o[ch]. Existing contents are preserved.
- ovf_clr_i clears ovf_o. If a new overflow happens in the same cycle, the set wins.
- Output stage:
  - One output register.
  - When the register is empty, or when it is accepted this cycle (valid && ready), load from the next non-empty FIFO in round-robin order, starting after the last channel served.
  - Outputs are stable while out_valid_o && !out_ready_i.

## Timing
- Reset values: out_valid_o, out_data_o, out_ch_o, out_ferr_o, out_perr_o, ovf_o all 0. FSMs in IDLE, FIFOs empty, round-robin pointer at 0.
- Line edge to FSM visibility: 2 cycles (synchroniser).
- Stop-bit sample in cycle S gives FIFO write in S and out_valid_o in S+1, provided the FIFO was empty and the output register was free.
- Back-to-back transfer: one byte per cycle under continuous out_ready_i.
- Simultaneous pushes on all channels are accepted in the same cycle; each FIFO is independent.
- Simultaneous push and pop on a full FIFO: the pop frees the slot, so the push succeeds and no overflow is flagged.
- Reset asserted mid-frame discards the partial frame and FIFO contents. After release, a line that is already low is treated as a start bit.

## Configuration
- UART_MON_PARITY_EN defined: the PAR state exists, PARITY selects odd or even, and out_perr_o is live.
- Macro undefined: there is no PAR state, the PARITY parameter is ignored, frames are start + DATA_BITS + stop, and out_perr_o is constant 0.

## Structure
- Package uart_mon_pkg holds:
  - the rx_state_e enum
  - the parity_e enum (PAR_NONE, PAR_ODD, PAR_EVEN)
  - the calc_div(CLK_HZ, BAUD) function
  - the entry struct {data, ferr, perr}
- Sub-module uart_mon_rx_ch: synchroniser, bit counter, divider counter, FSM and push strobe for one channel. Instantiated NCH times via generate.
- The top level contains the per-channel FIFOs, the round-robin arbiter and the output register.

## Test plan
- Channel 0 receives 0x55 at 115200, 8N1, out_ready_i held high. Expect out_data_o = 0x55, out_ch_o = 0, both error flags 0, out_valid_o asserted exactly 1 cycle after the stop sample.
- Channel 1 gets a 1.5 µs low glitch (false start). Expect no push and the FSM back in IDLE. A following 0xA3 is received correctly.
- Channel 0 sends 0x41 with the stop bit forced low for 3 bit times. Expect 0x41 with out_ferr_o = 1. A subsequent 0x42 after the line returns high has ferr = 0.
- Hold out_ready_i low while channel 0 sends 17 bytes, 0x00..0x10. Expect ovf_o[0] = 1 and the FIFO holding 0x00..0x0F; 0x10 is dropped. Pulse ovf_clr_i and expect ovf_o = 0.
- Both channels send simultaneously, 0x11 on channel 0 and 0x22 on channel 1. Expect output order ch0 then ch1; then swap to ch1 first after the next concurrent pair.
- With UART_MON_PARITY_EN and PARITY = 2 (even), send 0x07 with a wrong parity bit of 0. Expect out_perr_o = 1 and the data intact.

Source files
------------

// File: rtl/uart_mon_pkg.sv
// Shared types and helpers for the multi-channel UART receive monitor.
// Holds the per-channel FSM states, the parity modes, the divider calculation and the FIFO entry layout.
package uart_mon_pkg;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PAR,
        RX_STOP,
        RX_BRK
    } rx_state_e;

    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_ODD  = 2'd1,
        PAR_EVEN = 2'd2
    } parity_e;

    localparam int MAX_DATA_BITS = 8;

    typedef struct packed {
        logic [MAX_DATA_BITS-1:0] data;
        logic                     ferr;
        logic                     perr;
    } entry_t;

    // Rounded clocks per bit.
    function automatic int calc_div(input int clk_hz, input int baud);
        return (clk_hz + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/uart_mon_fifo.sv
// Generic single-clock FIFO; DEPTH must be a power of two, at least 2.
// Latency: write visible on rdata_o the cycle after the push; read is combinational from the head.
// Backpressure: writes when full are ignored unless a read frees the slot in the same cycle.
module uart_mon_fifo #(
    parameter int DEPTH = 16,
    parameter int W     = 10
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic         wr_i,
    input  logic [W-1:0] wdata_i,
    input  logic         rd_i,
    output logic [W-1:0] rdata_o,
    output logic         full_o,
    output logic         empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem_q [DEPTH];
    logic [AW:0]  wptr_q, rptr_q;
    logic         do_wr, do_rd;

    assign empty_o = (wptr_q == rptr_q);
    assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign do_rd   = rd_i && !empty_o;
    assign do_wr   = wr_i && (!full_o || do_rd);
    assign rdata_o = mem_q[rptr_q[AW-1:0]];

    always_ff @(posedge clk_i) begin
        if (do_wr) begin
            mem_q[wptr_q[AW-1:0]] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (do_wr) wptr_q <= wptr_q + 1'b1;
            if (do_rd) rptr_q <= rptr_q + 1'b1;
        end
    end

endmodule

// File: rtl/uart_mon_rx_ch.sv
// One UART RX lane: 2-FF synchroniser, bit timing and frame FSM; parity only with UART_MON_PARITY_EN.
// Latency: push_o pulses in the stop-bit sample cycle, 2 cycles of synchroniser delay behind the line.
// Backpressure: none; the lane never stalls, the consumer must take push_o when it fires.
module uart_mon_rx_ch
    import uart_mon_pkg::*;
#(
    parameter int CLK_HZ    = 25000000,
    parameter int BAUD      = 115200,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0
) (
    input  logic   clk_i,
    input  logic   rst_n_i,
    input  logic   rx_i,
    output logic   push_o,
    output entry_t entry_o
);
    localparam int DIV  = calc_div(CLK_HZ, BAUD);
    localparam int HALF = DIV / 2;
    localparam int CW   = $clog2(DIV + 1);
`ifdef UART_MON_PARITY_EN
    localparam bit PAR_BUILD = 1'b1;
`else
    localparam bit PAR_BUILD = 1'b0;
`endif
    localparam bit USE_PAR = PAR_BUILD && (PARITY != int'(PAR_NONE));

    logic [1:0]    sync_q;
    rx_state_e     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          perr_q, perr_d;
    logic [7:0]    data_w;
    logic          rx_s, tick;

    assign rx_s   = sync_q[1];
    // Bits enter at the MSB, so short frames end up left-aligned in the shifter.
    assign data_w = shift_q >> (8 - DATA_BITS);
    assign tick   = (state_q == RX_START) ? (cnt_q == CW'(HALF - 1)) : (cnt_q == CW'(DIV - 1));

`ifdef UART_MON_PARITY_EN
    logic par_exp;
    assign par_exp = (^data_w) ^ (PARITY == int'(PAR_ODD));
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        bit_d   = bit_q;
        shift_d = shift_q;
        perr_d  = perr_q;
        push_o  = 1'b0;
        case (state_q)
            RX_IDLE: begin
                cnt_d = '0;
                if (!rx_s) begin
                    state_d = RX_START;
                    perr_d  = 1'b0;
                end
            end
            RX_START: begin
                if (tick) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = rx_s ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (tick) begin
                    cnt_d   = '0;
                    shift_d = {rx_s, shift_q[7:1]};
                    bit_d   = bit_q + 1'b1;
                    if (bit_q == 3'(DATA_BITS - 1)) begin
                        state_d = USE_PAR ? RX_PAR : RX_STOP;
                    end
                end
            end
`ifdef UART_MON_PARITY_EN
            RX_PAR: begin
                if (tick) begin
                    cnt_d   = '0;
                    perr_d  = (rx_s != par_exp);
                    state_d = RX_STOP;
                end
            end
`endif
            RX_STOP: begin
                if (tick) begin
                    cnt_d   = '0;
                    push_o  = 1'b1;
                    state_d = rx_s ? RX_IDLE : RX_BRK;
                end
            end
            RX_BRK: begin
                cnt_d = '0;
                if (rx_s) state_d = RX_IDLE;
            end
            default: state_d = RX_IDLE;
        endcase
    end

    assign entry_o = '{data: data_w, ferr: ~rx_s, perr: perr_q};

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sync_q  <= 2'b11;
            state_q <= RX_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            perr_q  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], rx_i};
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            perr_q  <= perr_d;
        end
    end

endmodule

// File: rtl/uart_mon_rx_mc.sv
// NCH-lane UART receive monitor merging per-lane FIFOs into one tagged byte stream (parity via UART_MON_PARITY_EN).
// Latency: stop-bit sample in cycle S gives out_valid_o in S+1 when the lane FIFO and output register are free.
// Backpressure: out_ready_i low holds the output stable; full lane FIFOs drop new bytes and set sticky ovf_o.
module uart_mon_rx_mc
    import uart_mon_pkg::*;
#(
    parameter int NCH        = 2,
    parameter int CLK_HZ     = 25000000,
    parameter int BAUD       = 115200,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                                   clk_i,
    input  logic                                   rst_n_i,
    input  logic [NCH-1:0]                         rx_i,
    output logic                                   out_valid_o,
    input  logic                                   out_ready_i,
    output logic [DATA_BITS-1:0]                   out_data_o,
    output logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0] out_ch_o,
    output logic                                   out_ferr_o,
    output logic                                   out_perr_o,
    output logic [NCH-1:0]                         ovf_o,
    input  logic                                   ovf_clr_i
);
    localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int EW  = $bits(entry_t);

    logic [NCH-1:0] push, fifo_wr, fifo_rd, fifo_full, fifo_empty, avail, pop, ovf_set;
    entry_t         rx_ent    [NCH];
    entry_t         fifo_dout [NCH];
    entry_t         head      [NCH];
    entry_t         sel_ent;

    logic                 load, sel_vld;
    logic [CHW-1:0]       sel, cand, rr_q, rr_d;
    logic                 out_valid_q, out_valid_d;
    logic [DATA_BITS-1:0] out_data_q, out_data_d;
    logic [CHW-1:0]       out_ch_q, out_ch_d;
    logic                 out_ferr_q, out_ferr_d, out_perr_q, out_perr_d;
    logic [NCH-1:0]       ovf_q, ovf_d;

    assign load = !out_valid_q || out_ready_i;

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        uart_mon_rx_ch #(
            .CLK_HZ    (CLK_HZ),
            .BAUD      (BAUD),
            .DATA_BITS (DATA_BITS),
            .PARITY    (PARITY)
        ) u_rx (
            .clk_i   (clk_i),
            .rst_n_i (rst_n_i),
            .rx_i    (rx_i[c]),
            .push_o  (push[c]),
            .entry_o (rx_ent[c])
        );

        uart_mon_fifo #(
            .DEPTH (FIFO_DEPTH),
            .W     (EW)
        ) u_fifo (
            .clk_i   (clk_i),
            .rst_n_i (rst_n_i),
            .wr_i    (fifo_wr[c]),
            .wdata_i (rx_ent[c]),
            .rd_i    (fifo_rd[c]),
            .rdata_o (fifo_dout[c]),
            .full_o  (fifo_full[c]),
            .empty_o (fifo_empty[c])
        );

        // An empty FIFO is bypassed so a fresh byte reaches the output one cycle after its stop sample.
        assign avail[c]   = !fifo_empty[c] || push[c];
        assign head[c]    = fifo_empty[c] ? rx_ent[c] : fifo_dout[c];
        assign pop[c]     = load && sel_vld && (sel == CHW'(c));
        assign fifo_rd[c] = pop[c] && !fifo_empty[c];
        assign fifo_wr[c] = push[c] && !(fifo_empty[c] && pop[c]);
        assign ovf_set[c] = push[c] && fifo_full[c] && !pop[c];
    end

    // Round-robin search starts at the lane after the one served last.
    always_comb begin
        sel_vld = 1'b0;
        sel     = rr_q;
        cand    = '0;
        for (int k = 1; k <= NCH; k++) begin
            cand = CHW'((int'(rr_q) + k) % NCH);
            if (!sel_vld && avail[cand]) begin
                sel_vld = 1'b1;
                sel     = cand;
            end
        end
    end

    assign sel_ent = head[sel];

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        out_ferr_d  = out_ferr_q;
        out_perr_d  = out_perr_q;
        rr_d        = rr_q;
        if (load) begin
            out_valid_d = sel_vld;
            if (sel_vld) begin
                out_data_d = sel_ent.data[DATA_BITS-1:0];
                out_ch_d   = sel;
                out_ferr_d = sel_ent.ferr;
                out_perr_d = sel_ent.perr;
                rr_d       = sel;
            end
        end
        ovf_d = (ovf_q & ~{NCH{ovf_clr_i}}) | ovf_set;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            out_ferr_q  <= 1'b0;
            out_perr_q  <= 1'b0;
            rr_q        <= '0;
            ovf_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            out_ferr_q  <= out_ferr_d;
            out_perr_q  <= out_perr_d;
            rr_q        <= rr_d;
            ovf_q       <= ovf_d;
        end
    end

    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign out_ch_o    = out_ch_q;
    assign out_ferr_o  = out_ferr_q;
    assign out_perr_o  = out_perr_q;
    assign ovf_o       = ovf_q;

endmodule

// File: tb/tb_uart_mon_rx_mc.sv
// Directed bench for uart_mon_rx_mc: 2 lanes, 25 MHz, 115200 baud, 8 data bits, 16-entry FIFOs.
module tb_uart_mon_rx_mc;
    localparam int NCH = 2;
    localparam int DATA_BITS = 8;
    localparam int DIV = 217;
    localparam int HALF = 108;
`ifdef UART_MON_PARITY_EN
    localparam int NPAR = 1;
`else
    localparam int NPAR = 0;
`endif
    localparam int STOP_IDX = 1 + DATA_BITS + NPAR;
    localparam int VLAT = 3 + HALF + STOP_IDX * DIV;

    logic           clk_i = 1'b0;
    logic           rst_n_i = 1'b0;
    logic [NCH-1:0] rx_i = '1;
    logic           out_valid_o;
    logic           out_ready_i = 1'b1;
    logic [7:0]     out_data_o;
    logic [0:0]     out_ch_o;
    logic           out_ferr_o, out_perr_o;
    logic [NCH-1:0] ovf_o;
    logic           ovf_clr_i = 1'b0;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    typedef struct {
        logic [7:0] d;
        int         ch;
        logic       ferr;
        logic       perr;
        int         cyc;
    } rec_t;
    rec_t q[$];
    rec_t mon_r;

    uart_mon_rx_mc #(
        .NCH(NCH), .CLK_HZ(25000000), .BAUD(115200),
        .DATA_BITS(DATA_BITS), .PARITY(2), .FIFO_DEPTH(16)
    ) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .rx_i(rx_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .out_data_o(out_data_o), .out_ch_o(out_ch_o),
        .out_ferr_o(out_ferr_o), .out_perr_o(out_perr_o),
        .ovf_o(ovf_o), .ovf_clr_i(ovf_clr_i)
    );

    always #20 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    always @(negedge clk_i) begin
        if (rst_n_i && out_valid_o && out_ready_i) begin
            mon_r.d = out_data_o;
            mon_r.ch = int'(out_ch_o);
            mon_r.ferr = out_ferr_o;
            mon_r.perr = out_perr_o;
            mon_r.cyc = cyc;
            q.push_back(mon_r);
        end
    end

    initial begin
        #20000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic logic fbit(input logic [7:0] b, input int i, input logic bad);
        if (i == 0) return 1'b0;
        if (i <= DATA_BITS) return b[i-1];
        return (^b) ^ bad;
    endfunction

    // Drives one frame on each lane selected by en, in lockstep.
    task automatic send(input logic [1:0] en, input logic [7:0] b0, input logic [7:0] b1,
                        input int stop_low, input logic bad_par);
        @(posedge clk_i);
        #1;
        for (int i = 0; i < STOP_IDX; i++) begin
            rx_i[0] = en[0] ? fbit(b0, i, bad_par) : 1'b1;
            rx_i[1] = en[1] ? fbit(b1, i, bad_par) : 1'b1;
            repeat (DIV) @(posedge clk_i);
            #1;
        end
        if (stop_low > 0) begin
            rx_i = ~en;
            repeat (stop_low * DIV) @(posedge clk_i);
            #1;
        end
        rx_i = 2'b11;
        repeat (DIV) @(posedge clk_i);
    endtask

    task automatic test_reset();
        rst_n_i = 1'b0;
        repeat (5) @(posedge clk_i);
        @(negedge clk_i);
        checks++;
        if ({out_valid_o, out_data_o, out_ch_o, out_ferr_o, out_perr_o, ovf_o} !== 13'h0) begin
            failures++;
            $display("FAIL reset_in: got %h required 0", {out_valid_o, out_data_o, out_ch_o, out_ferr_o, out_perr_o, ovf_o});
        end
        rst_n_i = 1'b1;
        repeat (20) @(posedge clk_i);
        @(negedge clk_i);
        checks++;
        if (out_valid_o !== 1'b0 || ovf_o !== 2'b00 || out_data_o !== 8'h00) begin
            failures++;
            $display("FAIL reset_after: valid=%b ovf=%b data=%h required 0", out_valid_o, ovf_o, out_data_o);
        end
    endtask

    task automatic test_basic();
        q.delete();
        fork
            send(2'b01, 8'h55, 8'h00, 0, 1'b0);
            begin
                @(posedge clk_i);
                repeat (VLAT - 1) @(posedge clk_i);
                @(negedge clk_i);
                checks++;
                if (out_valid_o !== 1'b0) begin
                    failures++;
                    $display("FAIL basic_early_valid: got %b required 0", out_valid_o);
                end
                @(posedge clk_i);
                @(negedge clk_i);
                checks++;
                if (out_valid_o !== 1'b1 || out_data_o !== 8'h55 || out_ch_o !== 1'b0 ||
                    out_ferr_o !== 1'b0 || out_perr_o !== 1'b0) begin
                    failures++;
                    $display("FAIL basic_byte: valid=%b data=%h ch=%0d ferr=%b perr=%b required 1/55/0/0/0",
                             out_valid_o, out_data_o, out_ch_o, out_ferr_o, out_perr_o);
                end
                @(posedge clk_i);
                @(negedge clk_i);
                checks++;
                if (out_valid_o !== 1'b0) begin
                    failures++;
                    $display("FAIL basic_single: valid got %b required 0", out_valid_o);
                end
            end
        join
        checks++;
        if (q.size() != 1) begin
            failures++;
            $display("FAIL basic_count: got %0d required 1", q.size());
        end
    endtask

    task automatic test_ferr();
        q.delete();
        send(2'b01, 8'h41, 8'h00, 3, 1'b0);
        send(2'b01, 8'h42, 8'h00, 0, 1'b0);
        repeat (5) @(posedge clk_i);
        @(negedge clk_i);
        checks++;
        if (q.size() != 2) begin
            failures++;
            $display("FAIL ferr_count: got %0d required 2", q.size());
        end else begin
            checks++;
            if (q[0].d !== 8'h41 || q[0].ferr !== 1'b1 || q[0].ch != 0) begin
                failures++;
                $display("FAIL ferr_bad_frame: data=%h ferr=%b ch=%0d required 41/1/0", q[0].d, q[0].ferr, q[0].ch);
            end
            checks++;
            if (q[1].d !== 8'h42 || q[1].ferr !== 1'b0 || q[1].perr !== 1'b0) begin
                failures++;
                $display("FAIL ferr_next_frame: data=%h ferr=%b perr=%b required 42/0/0", q[1].d, q[1].ferr, q[1].perr);
            end
        end
    endtask

    task automatic test_false_start();
        q.delete();
        @(posedge clk_i);
        #1 rx_i[1] = 1'b0;
        repeat (38) @(posedge clk_i);
        #1 rx_i[1] = 1'b1;
        repeat (400) @(posedge clk_i);
        @(negedge clk_i);
        checks++;
        if (q.size() != 0 || out_valid_o !== 1'b0) begin
            failures++;
            $display("FAIL glitch_push: got %0d bytes valid=%b required 0/0", q.size(), out_valid_o);
        end
        send(2'b10, 8'h00, 8'hA3, 0, 1'b0);
        repeat (5) @(posedge clk_i);
        @(negedge clk_i);
        checks++;
        if (q.size() != 1) begin
            failures++;
            $display("FAIL glitch_after_count: got %0d required 1", q.size());
        end else if (q[0].d !== 8'hA3 || q[0].ch != 1 || q[0].ferr !== 1'b0) begin
            failures++;
            $display("FAIL glitch_after_byte: data=%h ch=%0d ferr=%b required a3/1/0", q[0].d, q[0].ch, q[0].ferr);
        end
    endtask

    task automatic test_rr();
        logic [7:0] exp_d [5];
        int         exp_c [5];
        exp_d[0] = 8'h11; exp_c[0] = 0;
        exp_d[1] = 8'h22; exp_c[1] = 1;
        exp_d[2] = 8'h33; exp_c[2] = 0;
        exp_d[3] = 8'h66; exp_c[3] = 1;
        exp_d[4] = 8'h44; exp_c[4] = 0;
        q.delete();
        send(2'b11, 8'h11, 8'h22, 0, 1'b0);
        send(2'b01, 8'h33, 8'h00, 0, 1'b0);
        send(2'b11, 8'h44, 8'h66, 0, 1'b0);
        repeat (5) @(posedge clk_i);
        @(negedge clk_i);
        checks++;
        if (q.size() != 5) begin
            failures++;
            $display("FAIL rr_count: got %0d required 5", q.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (q[i].d !== exp_d[i] || q[i].ch != exp_c[i]) begin
                    failures++;
                    $display("FAIL rr_order[%0d]: data=%h ch=%0d required %h/%0d", i, q[i].d, q[i].ch, exp_d[i], exp_c[i]);
                end
            end
            checks++;
            if (q[1].cyc != q[0].cyc + 1) begin
                failures++;
                $display("FAIL rr_same_cycle_push: second byte at +%0d required +1", q[1].cyc - q[0].cyc);
            end
        end
    endtask

    task automatic test_overflow();
        q.delete();
        @(posedge clk_i);
        #1 out_ready_i = 1'b0;
        send(2'b10, 8'h00, 8'hEE, 0, 1'b0);
        @(negedge clk_i);
        checks++;
        if (out_valid_o !== 1'b1 || out_data_o !== 8'hEE || out_ch_o !== 1'b1) begin
            failures++;
            $display("FAIL ovf_hold_first: valid=%b data=%h ch=%0d required 1/ee/1", out_valid_o, out_data_o, out_ch_o);
        end
        for (int i = 0; i < 17; i++) send(2'b01, 8'(i), 8'h00, 0, 1'b0);
        @(negedge clk_i);
        checks++;
        if (out_valid_o !== 1'b1 || out_data_o !== 8'hEE || out_ch_o !== 1'b1) begin
            failures++;
            $display("FAIL ovf_hold_stable: valid=%b data=%h ch=%0d required 1/ee/1", out_valid_o, out_data_o, out_ch_o);
        end
        checks++;
        if (ovf_o !== 2'b01) begin
            failures++;
            $display("FAIL ovf_set: got %b required 01", ovf_o);
        end
        @(posedge clk_i);
        #1 ovf_clr_i = 1'b1;
        @(posedge clk_i);
        #1 ovf_clr_i = 1'b0;
        @(negedge clk_i);
        checks++;
        if (ovf_o !== 2'b00) begin
            failures++;
            $display("FAIL ovf_clear: got %b required 00", ovf_o);
        end
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL ovf_no_accept: got %0d bytes required 0", q.size());
        end
        @(posedge clk_i);
        #1 out_ready_i = 1'b1;
        repeat (30) @(posedge clk_i);
        @(negedge clk_i);
        checks++;
        if (q.size() != 17) begin
            failures++;
            $display("FAIL drain_count: got %0d required 17", q.size());
        end else begin
            checks++;
            if (q[0].d !== 8'hEE || q[0].ch != 1) begin
                failures++;
                $display("FAIL drain_first: data=%h ch=%0d required ee/1", q[0].d, q[0].ch);
            end
            for (int i = 1; i < 17; i++) begin
                checks++;
                if (q[i].d !== 8'(i - 1) || q[i].ch != 0 || q[i].cyc != q[0].cyc + i) begin
                    failures++;
                    $display("FAIL drain[%0d]: data=%h ch=%0d at +%0d required %h/0/+%0d",
                             i, q[i].d, q[i].ch, q[i].cyc - q[0].cyc, 8'(i - 1), i);
                end
            end
        end
        checks++;
        if (out_valid_o !== 1'b0) begin
            failures++;
            $display("FAIL drain_empty: valid got %b required 0", out_valid_o);
        end
    endtask

`ifdef UART_MON_PARITY_EN
    task automatic test_parity();
        q.delete();
        send(2'b01, 8'h07, 8'h00, 0, 1'b1);
        repeat (5) @(posedge clk_i);
        @(negedge clk_i);
        checks++;
        if (q.size() != 1) begin
            failures++;
            $display("FAIL parity_count: got %0d required 1", q.size());
        end else if (q[0].d !== 8'h07 || q[0].perr !== 1'b1 || q[0].ferr !== 1'b0) begin
            failures++;
            $display("FAIL parity_err: data=%h perr=%b ferr=%b required 07/1/0", q[0].d, q[0].perr, q[0].ferr);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_ferr();
        test_false_start();
        test_rr();
        test_overflow();
`ifdef UART_MON_PARITY_EN
        test_parity();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
